// File: rtl/buzzer_sequencer.sv
// Avalon-MM buzzer sequencer: plays REPEAT beeps (or runs continuously) with
// programmable ON/OFF lengths in ticks and an optional square-wave tone.
module buzzer_sequencer #(
  parameter int TICK_DIV = 50000,
  parameter int TIME_W   = 16,
  parameter int REP_W    = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic        buzzer_out
);

  localparam int PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

  state_t              state;
  logic                irq_en;
  logic                done;
  logic [TIME_W-1:0]   tone_half;
  logic [TIME_W-1:0]   on_ticks;
  logic [TIME_W-1:0]   off_ticks;
  logic [REP_W-1:0]    repeat_cnt;
  logic [REP_W-1:0]    remain;
  logic [TIME_W-1:0]   phase_len;
  logic [TIME_W-1:0]   tick_cnt;
  logic [TIME_W-1:0]   tone_cnt;
  logic [PRESC_W-1:0]  presc;

  logic wr_en, wr_ctrl, wr_status, start, stop;
  logic tick_end, phase_end, seq_done;
  logic done_next, irq_en_next;
  logic [TIME_W-1:0] on_len, off_len;
  logic unused_wdata;

  assign wr_en       = chipselect & ~write_n;
  assign wr_ctrl     = wr_en && (address == 3'd0);
  assign wr_status   = wr_en && (address == 3'd1);
  // STOP beats START when both bits arrive in one write.
  assign stop        = wr_ctrl & writedata[1];
  assign start       = wr_ctrl & writedata[0] & ~writedata[1];
  assign unused_wdata = ^writedata;

  assign on_len    = (on_ticks  == '0) ? TIME_W'(1) : on_ticks;
  assign off_len   = (off_ticks == '0) ? TIME_W'(1) : off_ticks;
  assign tick_end  = (presc == PRESC_W'(TICK_DIV - 1));
  assign phase_end = tick_end && (tick_cnt == phase_len - TIME_W'(1));
  // remain is nonzero only in counted mode, so remain==1 marks the last beep.
  assign seq_done  = (state == S_ON) && phase_end && (remain == REP_W'(1)) && !start && !stop;

  always_comb begin
    done_next   = done;
    irq_en_next = irq_en;
    if (wr_status && writedata[1]) done_next = 1'b0;
    if (seq_done)                  done_next = 1'b1;
    if (start)                     done_next = 1'b0;
    if (wr_ctrl)                   irq_en_next = writedata[2];
  end

  always_comb begin
    readdata = '0;
    case (address)
      3'd0:    readdata = {29'b0, irq_en, 2'b00};
      3'd1:    readdata = {30'b0, done, (state != S_IDLE)};
      3'd2:    readdata = 32'(tone_half);
      3'd3:    readdata = 32'(on_ticks);
      3'd4:    readdata = 32'(off_ticks);
      3'd5:    readdata = 32'(repeat_cnt);
      3'd6:    readdata = 32'(remain);
      default: readdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      irq_en     <= 1'b0;
      done       <= 1'b0;
      irq        <= 1'b0;
      buzzer_out <= 1'b0;
      tone_half  <= '0;
      on_ticks   <= '0;
      off_ticks  <= '0;
      repeat_cnt <= '0;
      remain     <= '0;
      phase_len  <= '0;
      tick_cnt   <= '0;
      tone_cnt   <= '0;
      presc      <= '0;
    end else begin
      done   <= done_next;
      irq_en <= irq_en_next;
      irq    <= done_next & irq_en_next;
      if (wr_en && address == 3'd2) tone_half  <= writedata[TIME_W-1:0];
      if (wr_en && address == 3'd3) on_ticks   <= writedata[TIME_W-1:0];
      if (wr_en && address == 3'd4) off_ticks  <= writedata[TIME_W-1:0];
      if (wr_en && address == 3'd5) repeat_cnt <= writedata[REP_W-1:0];

      if (stop) begin
        state      <= S_IDLE;
        buzzer_out <= 1'b0;
        remain     <= '0;
      end else if (start) begin
        state      <= S_ON;
        buzzer_out <= 1'b1;
        presc      <= '0;
        tick_cnt   <= '0;
        phase_len  <= on_len;
        tone_cnt   <= tone_half - TIME_W'(1);
        remain     <= repeat_cnt;
      end else begin
        case (state)
          S_ON: begin
            if (phase_end) begin
              buzzer_out <= 1'b0;
              presc      <= '0;
              tick_cnt   <= '0;
              if (remain == REP_W'(1)) begin
                state  <= S_IDLE;
                remain <= '0;
              end else begin
                state     <= S_OFF;
                phase_len <= off_len;
              end
            end else begin
              if (tick_end) begin
                presc    <= '0;
                tick_cnt <= tick_cnt + TIME_W'(1);
              end else begin
                presc <= presc + PRESC_W'(1);
              end
              if (tone_half == '0) begin
                buzzer_out <= 1'b1;
              end else if (tone_cnt == '0) begin
                buzzer_out <= ~buzzer_out;
                tone_cnt   <= tone_half - TIME_W'(1);
              end else begin
                tone_cnt <= tone_cnt - TIME_W'(1);
              end
            end
          end
          S_OFF: begin
            if (phase_end) begin
              state      <= S_ON;
              buzzer_out <= 1'b1;
              presc      <= '0;
              tick_cnt   <= '0;
              phase_len  <= on_len;
              tone_cnt   <= tone_half - TIME_W'(1);
              if (remain > REP_W'(1)) remain <= remain - REP_W'(1);
            end else if (tick_end) begin
              presc    <= '0;
              tick_cnt <= tick_cnt + TIME_W'(1);
            end else begin
              presc <= presc + PRESC_W'(1);
            end
          end
          default: begin
            state      <= S_IDLE;
            buzzer_out <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Bench for buzzer_sequencer: directed and randomized runs compared cycle by
// cycle against a waveform model built from the beep/tone rules.
module tb_buzzer_sequencer;
  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;
  logic        buzzer_out;

  int checks = 0;
  int errors = 0;
  // Entry per cycle after START: {busy, remain[7:0], buzzer}.
  logic [9:0] exp_q[$];

  buzzer_sequencer #(.TICK_DIV(TD), .TIME_W(16), .REP_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .irq(irq), .buzzer_out(buzzer_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called shortly after a negedge; the write lands on the following posedge.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1;
    #1;
    d = readdata;
    chipselect = 1'b0;
  endtask

  function automatic void build(input int tone, input int on, input int off,
                                input int rep, input int limit);
    int on_c, off_c, b, rem;
    exp_q.delete();
    on_c  = ((on  == 0) ? 1 : on)  * TD;
    off_c = ((off == 0) ? 1 : off) * TD;
    b = 1;
    while (exp_q.size() < limit) begin
      rem = (rep == 0) ? 0 : rep - b + 1;
      for (int i = 0; i < on_c; i++)
        exp_q.push_back({1'b1, 8'(rem), (tone == 0) ? 1'b1 : (((i / tone) % 2) == 0)});
      if (rep != 0 && b == rep) break;
      for (int i = 0; i < off_c; i++)
        exp_q.push_back({1'b1, 8'(rem), 1'b0});
      b++;
    end
    while (exp_q.size() > limit) void'(exp_q.pop_back());
    if (rep != 0)
      for (int i = 0; i < 3; i++) exp_q.push_back(10'b0);
  endfunction

  // Program, START, then check ncheck cycles (0 = whole expected run).
  task automatic run(input int tone, input int on, input int off, input int rep,
                     input bit ie, input int ncheck);
    logic [31:0] d;
    logic [9:0]  e;
    int n;
    wr(3'd2, 32'(tone)); wr(3'd3, 32'(on)); wr(3'd4, 32'(off)); wr(3'd5, 32'(rep));
    wr(3'd0, ie ? 32'h5 : 32'h1);
    build(tone, on, off, rep, (rep == 0) ? ncheck : 100000);
    n = (ncheck == 0 || ncheck > exp_q.size()) ? exp_q.size() : ncheck;
    for (int k = 0; k < n; k++) begin
      if (k != 0) @(negedge clk);
      e = exp_q[k];
      chk($sformatf("buzzer_out c%0d", k), 32'(buzzer_out), 32'(e[0]));
      rd(3'd1, d);
      chk($sformatf("status c%0d", k), d, e[9] ? 32'h1 : ((rep != 0) ? 32'h2 : 32'h0));
      rd(3'd6, d);
      chk($sformatf("remain c%0d", k), d, 32'(e[8:1]));
      chk($sformatf("irq c%0d", k), 32'(irq), 32'(ie && rep != 0 && !e[9]));
    end
  endtask

  initial begin
    logic [31:0] d;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int a = 0; a < 7; a++) begin
      rd(3'(a), d);
      chk($sformatf("reset reg%0d", a), d, 32'h0);
      @(negedge clk);
    end
    chk("reset buzzer_out", 32'(buzzer_out), 32'h0);
    chk("reset irq", 32'(irq), 32'h0);
    wr(3'd2, 32'h1234);
    rd(3'd2, d);
    chk("tone_half rw", d, 32'h1234);
    @(negedge clk);

    run(0, 2, 3, 2, 1'b0, 0);
    run(3, 3, 1, 1, 1'b0, 0);

    run(0, 1, 1, 1, 1'b1, 0);
    wr(3'd1, 32'h2);
    chk("irq after clear", 32'(irq), 32'h0);
    rd(3'd1, d);
    chk("status after clear", d, 32'h0);

    run(0, 1, 1, 0, 1'b0, 18);
    wr(3'd0, 32'h2);
    chk("stop buzzer_out", 32'(buzzer_out), 32'h0);
    rd(3'd1, d);
    chk("stop status", d, 32'h0);
    rd(3'd6, d);
    chk("stop remain", d, 32'h0);
    @(negedge clk);
    chk("stop buzzer_out later", 32'(buzzer_out), 32'h0);

    run(0, 1, 2, 3, 1'b0, 17);
    run(0, 1, 2, 3, 1'b0, 0);

    run(2, 1, 1, 0, 1'b0, 5);
    wr(3'd0, 32'h3);
    chk("ctrl3 buzzer_out", 32'(buzzer_out), 32'h0);
    rd(3'd1, d);
    chk("ctrl3 status", d, 32'h0);
    rd(3'd0, d);
    chk("ctrl3 ctrl", d, 32'h0);
    @(negedge clk);
    wr(3'd0, 32'h3);
    rd(3'd1, d);
    chk("ctrl3 idle status", d, 32'h0);
    @(negedge clk);

    run(0, 2, 1, 2, 1'b0, 3);
    #1 reset_n = 1'b0;
    #1 chk("async reset buzzer_out", 32'(buzzer_out), 32'h0);
    @(negedge clk);
    rd(3'd1, d);
    chk("reset status", d, 32'h0);
    rd(3'd6, d);
    chk("reset remain", d, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int it = 0; it < 6; it++) begin
      run(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
          bit'($urandom_range(0, 1)), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
